// File: rtl/axis_eth_fcs_append.sv
// Transmit-side AXI4-Stream Ethernet FCS generator (8-bit): forwards payload, zero-pads short
// frames and appends the IEEE 802.3 CRC-32 least significant byte first.
module axis_eth_fcs_append #(
  parameter int unsigned ENABLE_PADDING   = 1,
  parameter int unsigned MIN_FRAME_LENGTH = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       busy
);

  localparam bit          PadEn     = (ENABLE_PADDING != 0);
  localparam logic [15:0] PadTarget = 16'(MIN_FRAME_LENGTH - 4);

  typedef enum logic [1:0] {StIdle, StPayload, StPad, StFcs} state_e;

  // Reflected CRC-32 update, one byte, LSB first (Galois form of 32'h04C11DB7).
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ 32'hEDB88320;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  state_e      state_q, state_d;
  logic [15:0] frame_ptr_q, frame_ptr_d, ptr_inc;
  logic [31:0] crc_q, crc_d, fcs_word;
  logic [1:0]  fcs_idx_q, fcs_idx_d;
  logic [7:0]  fcs_byte;
  logic        s_tready_q, s_tready_d;
  logic        s_accept;

  // Internal stream feeding the output skid buffer.
  logic [7:0]  tdata_int;
  logic        tvalid_int, tlast_int, tuser_int;
  logic        tready_int_q, tready_int_early;

  // Output skid buffer registers.
  logic [7:0]  m_tdata_q, tmp_tdata_q;
  logic        m_tvalid_q, m_tvalid_d, m_tlast_q, m_tuser_q;
  logic        tmp_tvalid_q, tmp_tvalid_d, tmp_tlast_q, tmp_tuser_q;
  logic        store_int_to_out, store_int_to_tmp, store_tmp_to_out;

  assign s_accept = s_axis_tvalid && s_tready_q;
  assign ptr_inc  = (frame_ptr_q == 16'hFFFF) ? 16'hFFFF : frame_ptr_q + 16'd1;
  assign fcs_word = ~crc_q;

  always_comb begin
    fcs_byte = 8'h00;
    unique case (fcs_idx_q)
      2'd0: fcs_byte = fcs_word[7:0];
      2'd1: fcs_byte = fcs_word[15:8];
      2'd2: fcs_byte = fcs_word[23:16];
      2'd3: fcs_byte = fcs_word[31:24];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    frame_ptr_d = frame_ptr_q;
    crc_d       = crc_q;
    fcs_idx_d   = fcs_idx_q;
    tdata_int   = 8'h00;
    tvalid_int  = 1'b0;
    tlast_int   = 1'b0;
    tuser_int   = 1'b0;

    unique case (state_q)
      StIdle, StPayload: begin
        if (s_accept) begin
          tdata_int   = s_axis_tdata;
          tvalid_int  = 1'b1;
          crc_d       = crc_step(crc_q, s_axis_tdata);
          frame_ptr_d = ptr_inc;
          state_d     = StPayload;
          if (s_axis_tlast) begin
            if (s_axis_tuser) begin
              // Errored frame: pass it through marked, without pad or FCS.
              tlast_int   = 1'b1;
              tuser_int   = 1'b1;
              state_d     = StIdle;
              crc_d       = '1;
              frame_ptr_d = 16'd0;
            end else if (PadEn && (ptr_inc < PadTarget)) begin
              state_d = StPad;
            end else begin
              state_d = StFcs;
            end
          end
        end
      end
      StPad: begin
        if (tready_int_q) begin
          tvalid_int  = 1'b1;
          crc_d       = crc_step(crc_q, 8'h00);
          frame_ptr_d = ptr_inc;
          if (ptr_inc >= PadTarget) begin
            state_d = StFcs;
          end
        end
      end
      StFcs: begin
        if (tready_int_q) begin
          tdata_int  = fcs_byte;
          tvalid_int = 1'b1;
          fcs_idx_d  = fcs_idx_q + 2'd1;
          if (fcs_idx_q == 2'd3) begin
            tlast_int   = 1'b1;
            state_d     = StIdle;
            crc_d       = '1;
            frame_ptr_d = 16'd0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Input is only open while accepting payload; PAD/FCS generation closes it.
  assign s_tready_d = ((state_d == StIdle) || (state_d == StPayload)) ? tready_int_early : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      frame_ptr_q <= 16'd0;
      crc_q       <= '1;
      fcs_idx_q   <= 2'd0;
      s_tready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_ptr_q <= frame_ptr_d;
      crc_q       <= crc_d;
      fcs_idx_q   <= fcs_idx_d;
      s_tready_q  <= s_tready_d;
    end
  end

  // Ready for next cycle if the output reg is free to take data or the temp reg is empty.
  assign tready_int_early = m_axis_tready || (!tmp_tvalid_q && (!m_tvalid_q || !tvalid_int));

  always_comb begin
    m_tvalid_d       = m_tvalid_q;
    tmp_tvalid_d     = tmp_tvalid_q;
    store_int_to_out = 1'b0;
    store_int_to_tmp = 1'b0;
    store_tmp_to_out = 1'b0;
    if (tready_int_q) begin
      if (m_axis_tready || !m_tvalid_q) begin
        m_tvalid_d       = tvalid_int;
        store_int_to_out = 1'b1;
      end else begin
        tmp_tvalid_d     = tvalid_int;
        store_int_to_tmp = 1'b1;
      end
    end else if (m_axis_tready) begin
      m_tvalid_d       = tmp_tvalid_q;
      tmp_tvalid_d     = 1'b0;
      store_tmp_to_out = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_tvalid_q   <= 1'b0;
      m_tdata_q    <= 8'h00;
      m_tlast_q    <= 1'b0;
      m_tuser_q    <= 1'b0;
      tmp_tvalid_q <= 1'b0;
      tmp_tdata_q  <= 8'h00;
      tmp_tlast_q  <= 1'b0;
      tmp_tuser_q  <= 1'b0;
      tready_int_q <= 1'b0;
    end else begin
      m_tvalid_q   <= m_tvalid_d;
      tmp_tvalid_q <= tmp_tvalid_d;
      tready_int_q <= tready_int_early;
      if (store_int_to_out) begin
        m_tdata_q <= tdata_int;
        m_tlast_q <= tlast_int;
        m_tuser_q <= tuser_int;
      end else if (store_tmp_to_out) begin
        m_tdata_q <= tmp_tdata_q;
        m_tlast_q <= tmp_tlast_q;
        m_tuser_q <= tmp_tuser_q;
      end
      if (store_int_to_tmp) begin
        tmp_tdata_q <= tdata_int;
        tmp_tlast_q <= tlast_int;
        tmp_tuser_q <= tuser_int;
      end
    end
  end

  assign s_axis_tready = s_tready_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tuser  = m_tuser_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: doc/axis_eth_fcs_append.md
# axis_eth_fcs_append

Transmit-side AXI4-Stream Ethernet FCS generator with optional minimum-length padding, 8-bit datapath. It sits between the TX frame source and the TX MAC/GMII encoder. It forwards payload bytes, zero-pads short frames to the minimum length, and appends the 4-byte IEEE 802.3 CRC-32, least significant byte first. It is the counterpart of the RX FCS checker and uses the same ve_lfsr CRC configuration.

## Interface
- ENABLE_PADDING, default 1: when 1, frames shorter than MIN_FRAME_LENGTH-4 payload bytes are zero-padded.
- MIN_FRAME_LENGTH, default 64: minimum frame length in bytes, FCS included. Legal range is 5..65535.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- s_axis_tdata  in  8  payload byte (destination MAC onward, no preamble)
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready (registered)
- s_axis_tlast  in  1  last payload byte
- s_axis_tuser  in  1  frame error, sampled on the tlast beat
- m_axis_tdata  out  8  output byte
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  last byte of frame (last FCS byte, or the errored last byte)
- m_axis_tuser  out  1  error flag on the tlast beat
- busy  out  1  high while a frame is in progress (state != IDLE)

## Operation
- CRC: ve_lfsr, width 32, polynomial 32'h04C11DB7, Galois, REVERSE=1, 8-bit data. State is initialised to 32'hFFFFFFFF. FCS = ~crc_state, sent as bytes [7:0], [15:8], [23:16], [31:24].
- frame_ptr: 16-bit byte counter. It counts payload and pad bytes emitted, saturates at 16'hFFFF, and clears on return to IDLE.
- Output stage: standard two-register skid buffer (output reg + temp reg) driven by m_axis_tready_int_early. No combinational path from m_axis_tready to s_axis_tready.
- IDLE: s_axis_tready = tready_int_early. CRC is held at the reset value.
  - On an accepted beat: forward the byte, update the CRC, set frame_ptr=1.
  - Without tlast: go to PAYLOAD. With tlast: apply the end-of-payload rule.
- PAYLOAD: forward each accepted byte, update the CRC, increment frame_ptr. On tlast, apply the end-of-payload rule.
- End-of-payload rule, evaluated on the tlast beat:
  - If s_axis_tuser=1: emit the byte with tlast=1, tuser=1. No pad, no FCS. Go to IDLE.
  - Else if ENABLE_PADDING and count (including this byte) < MIN_FRAME_LENGTH-4: emit the byte with tlast=0, then go to PAD.
  - Otherwise: emit the byte with tlast=0, then go to FCS.
  - In both non-error cases, deassert s_axis_tready on the next cycle.
- PAD: s_axis_tready=0. Emit 8'h00 bytes, updating CRC and frame_ptr. Go to FCS after the byte that brings frame_ptr to MIN_FRAME_LENGTH-4.
- FCS: s_axis_tready=0. Emit 4 FCS bytes via a 2-bit index. The 4th byte has tlast=1, tuser=0. Then go to IDLE, with s_axis_tready = tready_int_early and the CRC reset.
- Internal advance in PAD/FCS happens only on cycles where tready_int_reg=1.
- Input stall mid-frame (tvalid low in PAYLOAD): hold state, emit nothing. No underrun detection.

## Timing
- Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0, busy=0. State=IDLE, CRC=FFFFFFFF, frame_ptr=0. Temp reg is invalid.
- s_axis_tready rises the first cycle after reset deassertion if downstream is ready.
- Latency: an input beat accepted at cycle N appears on m_axis at cycle N+1 when downstream is ready.
- Throughput: 1 byte/clk sustained.
- Turnaround: the first byte of the next frame may be accepted on the cycle after the last FCS byte is pushed into the output stage. Minimum gap is 0 cycles on m_axis; inter-frame gap is the MAC's job.
- Backpressure: m_axis_tready low holds all output signals stable. No byte is lost or duplicated. At most one extra byte is captured in the temp reg.
- Reset mid-frame: immediate return to IDLE, output valid cleared, partial frame dropped. The next frame starts with a fresh CRC.

## Test plan
- Padding off, payload "123456789" (31..39) with tlast -> 9 bytes, then 26 39 F4 CB; tlast on CB, tuser=0, 13 beats.
- Padding on, 1-byte frame 8'h00 -> 60 bytes total (1 + 59 zero pad), then a 4-byte FCS matching a software CRC-32 of 60 zero bytes; 64 beats, tlast only on the last.
- Padding on, 60-byte and 100-byte frames -> no pad bytes; 64 and 104 beats; FCS matches the reference model. Also a 59-byte frame -> exactly 1 pad byte.
- Frame with s_axis_tuser=1 on tlast -> payload forwarded unchanged, last byte has tlast=1, tuser=1, no pad/FCS. The following good frame gets a correct FCS.
- Random m_axis_tready (50%) and random s_axis_tvalid gaps over 1000 frames of length 1..1514 -> output matches the model byte-for-byte; s_axis_tready=0 throughout every PAD/FCS phase.
- Assert rst for 1 cycle during FCS byte 2 -> m_axis_tvalid=0 the next cycle, busy=0. The next frame "123456789" yields FCS CB F4 39 26 (byte order 26 39 F4 CB).
